ddma_noc_vc_inbuf: RTL and testbench
====================================

Name: ddma_noc_vc_inbuf

Overview:
- Parametrised router input-port buffer for the ddma Hermes-style mesh, one instance per router port (EAST/WEST/NORTH/SOUTH/LOCAL).
- Generalises the single-channel credit link into NUM_VC virtual channels, each with its own FIFO and its own credit.
- Tracks Hermes packet framing per VC: header flit, then size flit, then payload flits.
- Raises a routing request per VC and streams the granted VC's packet to the crossbar under downstream per-VC credit.

Parameters:
- FLIT_WIDTH, 32, flit width in bits.
- NUM_VC, 2, number of virtual channels; 1..8.
- BUFFER_DEPTH, 8, flits per VC FIFO; power of two, at least 2.
- VC_W, $clog2(NUM_VC) with a minimum of 1, width of the VC index (derived).

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; reset=0 clears all state.
- rx  in  1  upstream flit valid.
- vc_i  in  VC_W  VC of the incoming flit.
- data_i  in  FLIT_WIDTH  incoming flit.
- credit_o  out  NUM_VC  per-VC space available to upstream.
- req_o  out  NUM_VC  per-VC routing request; header flit is at the FIFO head.
- header_o  out  NUM_VC*FLIT_WIDTH  per-VC head flit, VC v in slice [v*FLIT_WIDTH +: FLIT_WIDTH].
- grant_i  in  NUM_VC  one-hot grant from the switch allocator; held high for the whole packet.
- tx  out  1  flit valid to the crossbar.
- vc_o  out  VC_W  VC of the outgoing flit.
- data_o  out  FLIT_WIDTH  outgoing flit.
- credit_i  in  NUM_VC  downstream per-VC credit.
- release_o  out  NUM_VC  one-cycle pulse when a VC's last packet flit is sent.
- overflow_o  out  1  sticky: a flit arrived for a full VC.
- grant_err_o  out  1  sticky: grant_i was multi-hot, or granted a VC in IDLE.

Behaviour:
- Reset values:
  - All FIFOs empty, all VCs in IDLE, counters 0.
  - credit_o all 1; req_o, tx, release_o, overflow_o, grant_err_o all 0.
  - vc_o 0, data_o 0.
- Write side:
  - A push to VC v happens when rx=1, vc_i=v and the FIFO is not full (count_v < BUFFER_DEPTH) at the same edge.
  - credit_o[v] = (count_v != BUFFER_DEPTH). It is registered state and is not affected by a same-cycle pop.
  - rx=1 to a full VC: flit dropped, overflow_o set, held until reset.
  - vc_i >= NUM_VC: flit dropped, overflow_o set.
- Latency: a flit written at edge t is visible at the FIFO head (header_o / data_o) after edge t. Minimum 1-cycle cut-through.
- FIFO: circular buffer per VC; read and write pointers wrap modulo BUFFER_DEPTH.
  - Simultaneous push and pop on the same VC is legal, including when count=1 and when count=BUFFER_DEPTH-1; count is unchanged.
- Per-VC state machine (states IDLE, REQ, SIZE, PAYLOAD):
  - IDLE -> REQ when the FIFO is non-empty. The head flit is by definition a header.
  - REQ: req_o[v]=1, header_o slice shows the head flit. On the first header send -> SIZE.
  - SIZE: on send, load remaining = size flit value (full FLIT_WIDTH, unsigned). Size 0 -> IDLE with a release_o[v] pulse; otherwise -> PAYLOAD.
  - PAYLOAD: each send decrements remaining. The send with remaining=1 -> IDLE with a release_o[v] pulse.
  - req_o[v] drops in the cycle after the header is sent.
- Send condition for VC v: grant_i == one-hot(v), v not in IDLE, FIFO v non-empty, credit_i[v]=1.
  - On send: tx=1, vc_o=v, data_o = head flit, and the head is popped at that edge.
  - With no send: tx=0; data_o and vc_o hold their last values.
  - At most one flit per cycle leaves the block.
- Pausing:
  - Grant dropped mid-packet: transmission pauses, state and counter are retained, and the packet resumes on re-grant.
  - A FIFO that underruns mid-packet also pauses, with no error.
- Grant errors: multi-hot grant_i, or a grant to a VC in IDLE, produces no send and sets grant_err_o.
- Reset mid-packet: asynchronous clear of all FIFO contents and state. Any partial packet is discarded.

Test Plan:
- Reset low for 2 cycles, then release -> credit_o all 1, all other outputs 0. Drive rx=1 with 9 flits to VC0 at DEPTH=8 -> 8 stored, credit_o[0]=0 after the 8th, overflow_o=1 after the 9th.
- VC0 packet {header 0x0011, size 3, payloads 0xA, 0xB, 0xC}, grant_i=01, credit_i=11 -> req_o[0]=1 the cycle after the header is written. Exactly 5 tx cycles carry the five flits in order with vc_o=0, then release_o[0] pulses once.
- Interleave VC0 and VC1 packets at the input, grant VC1 first -> VC1 flits sent whole and in order; VC0 stays in REQ with header_o[0] stable until grant_i=01.
- Grant VC0 packet with size 4 and hold credit_i[0]=0 for 3 cycles after the size flit -> tx=0 during the stall, and all flits are delivered afterwards with no loss or duplication. Repeat the test dropping grant_i instead of the credit.
- Packet with size 0 -> 2 flits sent, release_o pulses with the size flit. grant_i=11 -> no tx, grant_err_o=1.
- Push 20 flits through VC0 with a continuous simultaneous pop -> pointers wrap, and output order equals input order. Assert reset mid-packet -> all outputs return to reset values immediately, and credit_o is all 1.

Source files
------------

// File: rtl/ddma_noc_vc_inbuf.sv
// ddma_noc_vc_inbuf: router input port with one FIFO per virtual channel, Hermes framing per VC,
// routing requests and credit-gated streaming of the granted VC to the crossbar.
module ddma_noc_vc_inbuf #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_VC = 2,
  parameter int BUFFER_DEPTH = 8,
  parameter int VC_W = NUM_VC > 1 ? $clog2(NUM_VC) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         rx,
  input  logic [VC_W-1:0]              vc_i,
  input  logic [FLIT_WIDTH-1:0]        data_i,
  output logic [NUM_VC-1:0]            credit_o,
  output logic [NUM_VC-1:0]            req_o,
  output logic [NUM_VC*FLIT_WIDTH-1:0] header_o,
  input  logic [NUM_VC-1:0]            grant_i,
  output logic                         tx,
  output logic [VC_W-1:0]              vc_o,
  output logic [FLIT_WIDTH-1:0]        data_o,
  input  logic [NUM_VC-1:0]            credit_i,
  output logic [NUM_VC-1:0]            release_o,
  output logic                         overflow_o,
  output logic                         grant_err_o
);
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, REQ, SIZE, PAYLOAD} state_t;
  logic [FLIT_WIDTH-1:0] mem [NUM_VC][BUFFER_DEPTH];
  logic [PW-1:0] rd_ptr [NUM_VC];
  logic [PW-1:0] wr_ptr [NUM_VC];
  logic [CW-1:0] count [NUM_VC];
  logic [FLIT_WIDTH-1:0] remaining [NUM_VC];
  logic [FLIT_WIDTH-1:0] head [NUM_VC];
  state_t state [NUM_VC];
  logic [NUM_VC-1:0] push, send, idle;
  logic drop, grant_bad;
  logic [FLIT_WIDTH-1:0] send_data;
  logic [VC_W-1:0] send_vc;
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign head[i] = mem[i][rd_ptr[i]];
    assign header_o[i*FLIT_WIDTH +: FLIT_WIDTH] = head[i];
    assign credit_o[i] = count[i] != CW'(BUFFER_DEPTH);
    assign req_o[i] = state[i] == REQ;
    assign idle[i] = state[i] == IDLE;
  end
  // a flit is dropped unless it addresses an existing VC that still has room
  always_comb begin
    push = '0;
    drop = rx;
    send = '0;
    send_data = '0;
    send_vc = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rx && vc_i == VC_W'(v)) begin
        push[v] = count[v] != CW'(BUFFER_DEPTH);
        drop = !push[v];
      end
      send[v] = $onehot(grant_i) && grant_i[v] && !idle[v] && count[v] != '0 && credit_i[v];
      if (send[v]) begin
        send_data = head[v];
        send_vc = VC_W'(v);
      end
    end
    grant_bad = (grant_i != '0 && !$onehot(grant_i)) || (grant_i & idle) != '0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        for (int d = 0; d < BUFFER_DEPTH; d++) mem[v][d] <= '0;
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v] <= '0;
        remaining[v] <= '0;
        state[v] <= IDLE;
      end
      tx <= 1'b0;
      vc_o <= '0;
      data_o <= '0;
      release_o <= '0;
      overflow_o <= 1'b0;
      grant_err_o <= 1'b0;
    end else begin
      tx <= |send;
      if (|send) begin
        vc_o <= send_vc;
        data_o <= send_data;
      end
      overflow_o <= overflow_o | drop;
      grant_err_o <= grant_err_o | grant_bad;
      release_o <= '0;
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) begin
          mem[v][wr_ptr[v]] <= data_i;
          wr_ptr[v] <= wr_ptr[v] + PW'(1);
        end
        if (send[v]) rd_ptr[v] <= rd_ptr[v] + PW'(1);
        count[v] <= count[v] + CW'(push[v]) - CW'(send[v]);
        // framing: header, then size flit, then exactly 'size' payload flits
        case (state[v])
          IDLE: if (count[v] != '0) state[v] <= REQ;
          REQ: if (send[v]) state[v] <= SIZE;
          SIZE: if (send[v]) begin
            remaining[v] <= head[v];
            state[v] <= head[v] == '0 ? IDLE : PAYLOAD;
            release_o[v] <= head[v] == '0;
          end
          default: if (send[v]) begin
            remaining[v] <= remaining[v] - FLIT_WIDTH'(1);
            if (remaining[v] == FLIT_WIDTH'(1)) begin
              state[v] <= IDLE;
              release_o[v] <= 1'b1;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ddma_noc_vc_inbuf.sv
// tb_ddma_noc_vc_inbuf: randomized packets per VC; expected flits queue per VC and a monitor
// compares every crossbar flit (data, order, release pulse) against them.
module tb_ddma_noc_vc_inbuf;
  logic clock = 0, reset = 0, rx = 0, vc_i = 0, tx, vc_o, overflow_o, grant_err_o;
  logic [31:0] data_i = 0, data_o;
  logic [1:0] credit_o, req_o, release_o, grant_i = 0, credit_i = 2'b11;
  logic [63:0] header_o;
  typedef struct packed {logic last; logic [31:0] d;} ent_t;
  ent_t q0[$], q1[$];
  int pass_cnt = 0, total_cnt = 0, tx_cnt = 0, rel_cnt = 0;

  always #5 clock = ~clock;

  ddma_noc_vc_inbuf dut (
    .clock(clock), .reset(reset), .rx(rx), .vc_i(vc_i), .data_i(data_i),
    .credit_o(credit_o), .req_o(req_o), .header_o(header_o), .grant_i(grant_i),
    .tx(tx), .vc_o(vc_o), .data_o(data_o), .credit_i(credit_i),
    .release_o(release_o), .overflow_o(overflow_o), .grant_err_o(grant_err_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    total_cnt++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin : mon
    ent_t e;
    if (reset) begin
      if (tx) begin
        tx_cnt++;
        if ((vc_o ? q1.size() : q0.size()) == 0) begin
          total_cnt++;
          $display("FAIL unexpected_tx: vc %0d data 0x%0h, expected no flit", vc_o, data_o);
        end else begin
          if (vc_o) e = q1.pop_front();
          else e = q0.pop_front();
          chk("data", {63'd0, vc_o} << 32 | data_o, {63'd0, vc_o} << 32 | e.d);
          chk("release", release_o, e.last ? (vc_o ? 2'b10 : 2'b01) : 2'b00);
        end
      end else if (release_o != 0) chk("stray_release", release_o, 0);
      if (release_o != 0) rel_cnt++;
    end
  end

  task automatic put(input int v, input logic [31:0] d, input logic last);
    int n = 0;
    while (!credit_o[v] && n < 200) begin tick(); n++; end
    if (!credit_o[v]) timeout("credit_wait");
    rx = 1;
    vc_i = v[0];
    data_i = d;
    if (v == 0) q0.push_back({last, d});
    else q1.push_back({last, d});
    tick();
    rx = 0;
  endtask

  task automatic pkt(input int v, input int size);
    put(v, $urandom, 0);
    put(v, size, size == 0);
    for (int i = 0; i < size; i++) put(v, $urandom, i == size - 1);
  endtask

  task automatic wait_req(input logic [1:0] g);
    int n = 0;
    while ((req_o & g) == 0 && n < 100) begin tick(); n++; end
    if ((req_o & g) == 0) timeout("req_wait");
  endtask

  task automatic wait_rel(input logic [1:0] g, input bit rc);
    int n = 0;
    do begin
      if (rc) credit_i = $urandom_range(0, 3) != 0 ? 2'b11 : 2'b00;
      tick();
      n++;
    end while ((release_o & g) == 0 && n < 400);
    if ((release_o & g) == 0) timeout("release_wait");
    credit_i = 2'b11;
  endtask

  task automatic grant_pkt(input logic [1:0] g, input bit rc);
    wait_req(g);
    grant_i = g;
    wait_rel(g, rc);
    grant_i = 0;
  endtask

  task automatic wait_tx(input int k);
    int c = 0, n = 0;
    while (c < k && n < 100) begin tick(); n++; if (tx) c++; end
    if (c < k) timeout("tx_wait");
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ctl"}, {credit_o, req_o, tx, vc_o, release_o, overflow_o, grant_err_o}, 10'h300);
    chk({name, "_data"}, data_o, 0);
    chk({name, "_hdr"}, header_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] h0;
    int c, r, v, sz;
    repeat (2) @(posedge clock);
    #1 reset = 1;
    chk_reset("after_reset");
    // fill VC0 to depth, then one flit too many
    pkt(0, 6);
    chk("full_credit", credit_o, 2'b10);
    chk("no_overflow_yet", overflow_o, 0);
    rx = 1; vc_i = 0; data_i = 32'hDEAD;
    tick();
    rx = 0;
    chk("overflow", overflow_o, 1);
    chk("still_full", credit_o, 2'b10);
    grant_pkt(2'b01, 0);
    tick();
    chk("fill_drained", q0.size(), 0);
    reset = 0;
    #1 chk_reset("reset_clears");
    tick();
    reset = 1;
    // directed packet: header, size 3, three payloads
    c = tx_cnt;
    r = rel_cnt;
    put(0, 32'h11, 0);
    tick();
    chk("req_after_hdr", req_o, 2'b01);
    chk("hdr_view", header_o[31:0], 32'h11);
    put(0, 3, 0); put(0, 32'hA, 0); put(0, 32'hB, 0); put(0, 32'hC, 1);
    grant_pkt(2'b01, 0);
    tick();
    chk("pkt_tx_cycles", tx_cnt - c, 5);
    chk("pkt_release_once", rel_cnt - r, 1);
    // interleaved arrival, VC1 granted first
    h0 = $urandom;
    put(0, h0, 0); put(1, $urandom, 0); put(0, 2, 0); put(1, 3, 0);
    put(0, $urandom, 0); put(1, $urandom, 0); put(0, $urandom, 1);
    put(1, $urandom, 0); put(1, $urandom, 1);
    grant_pkt(2'b10, 0);
    chk("vc0_waiting_req", req_o, 2'b01);
    chk("vc0_hdr_stable", header_o[31:0], h0);
    grant_pkt(2'b01, 0);
    tick();
    chk("interleave_q0", q0.size(), 0);
    chk("interleave_q1", q1.size(), 0);
    // credit stall after the size flit
    pkt(0, 4);
    wait_req(2'b01);
    grant_i = 2'b01;
    wait_tx(2);
    credit_i = 2'b10;
    for (int i = 0; i < 3; i++) begin tick(); chk("credit_stall_tx", tx, 0); end
    credit_i = 2'b11;
    wait_rel(2'b01, 0);
    grant_i = 0;
    // grant withdrawn mid-packet
    pkt(0, 4);
    wait_req(2'b01);
    grant_i = 2'b01;
    wait_tx(2);
    grant_i = 0;
    for (int i = 0; i < 3; i++) begin tick(); chk("grant_pause_tx", tx, 0); end
    grant_i = 2'b01;
    wait_rel(2'b01, 0);
    grant_i = 0;
    tick();
    chk("stall_q0", q0.size(), 0);
    chk("no_grant_err", grant_err_o, 0);
    // zero-size packet
    c = tx_cnt;
    pkt(0, 0);
    grant_pkt(2'b01, 0);
    tick();
    chk("size0_tx", tx_cnt - c, 2);
    // multi-hot grant
    pkt(0, 1);
    wait_req(2'b01);
    grant_i = 2'b11;
    tick();
    chk("multi_grant_tx", tx, 0);
    tick();
    chk("multi_grant_tx2", tx, 0);
    chk("grant_err", grant_err_o, 1);
    grant_i = 0;
    grant_pkt(2'b01, 0);
    tick();
    chk("gerr_q0", q0.size(), 0);
    // 20 flits streamed through VC0 while it drains
    c = tx_cnt;
    fork
      pkt(0, 18);
      grant_pkt(2'b01, 0);
    join
    tick();
    chk("wrap_tx", tx_cnt - c, 20);
    chk("wrap_q0", q0.size(), 0);
    // reset in the middle of a packet
    pkt(1, 5);
    wait_req(2'b10);
    grant_i = 2'b10;
    wait_tx(2);
    reset = 0;
    #1 chk_reset("mid_reset");
    q1.delete();
    grant_i = 0;
    tick();
    tick();
    reset = 1;
    // random packets with random downstream credit
    for (int k = 0; k < 8; k++) begin
      v = $urandom_range(0, 1);
      sz = $urandom_range(0, 5);
      pkt(v, sz);
      grant_pkt(v == 1 ? 2'b10 : 2'b01, 1);
    end
    tick();
    chk("rand_q0", q0.size(), 0);
    chk("rand_q1", q1.size(), 0);
    chk("rand_flags", {overflow_o, grant_err_o}, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
